// File: rtl/fir_tdm_pkg.sv
// Shared types and width helpers for the time-multiplexed multi-channel FIR.
package fir_tdm_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MAC, ST_OUT} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int prod_w(input int dw, input int cw);
      return dw + cw;
   endfunction

   // clog2(TAPS) guard bits keep a full channel sum from overflowing.
   function automatic int acc_w(input int dw, input int cw, input int taps);
      return dw + cw + clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate; clear has priority over enable, one-cycle update.
module fir_mac
   import fir_tdm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 35
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [COEF_W-1:0] b,
   output logic signed [ACC_W-1:0]  sum
);

   localparam int PROD_W = prod_w(DATA_W, COEF_W);

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc;

   assign prod     = a * b;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   // sum includes the current product so the last tap needs no extra cycle
   assign sum      = acc + prod_ext;

   always_ff @(posedge clk) begin
      if (rst)      acc <= '0;
      else if (clr) acc <= '0;
      else if (en)  acc <= sum;
   end

endmodule

// File: rtl/fir_tdm_multich.sv
// Multi-channel TAPS-tap FIR on one shared MAC with loadable coefficients.
// Define FIR_SAT_EN to clamp outputs instead of wrapping them.
module fir_tdm_multich
   import fir_tdm_pkg::*;
#(
   parameter  int NUM_CH = 3,
   parameter  int TAPS   = 8,
   parameter  int DATA_W = 16,
   parameter  int COEF_W = 16,
   parameter  int OUT_W  = 16,
   parameter  int SHIFT  = 15,
   localparam int TAP_AW = clog2(TAPS)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [TAP_AW-1:0]        coef_addr,
   input  logic [COEF_W-1:0]        coef_data,
   output logic                     coef_busy,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*OUT_W-1:0]  out_data
);

   localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
   localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

   state_t state, state_d;

   logic [TAP_AW-1:0]         tap_cnt;
   logic [CH_W-1:0]           ch_cnt;
   logic [NUM_CH*DATA_W-1:0]  in_lat;
   logic signed [DATA_W-1:0]  x    [NUM_CH][TAPS];
   logic signed [COEF_W-1:0]  coef [TAPS];
   logic signed [DATA_W-1:0]  x_sel;
   logic signed [COEF_W-1:0]  c_sel;
   logic signed [ACC_W-1:0]   mac_sum;
   logic                      mac_clr, mac_en, last_tap, last_ch;

   function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
      logic signed [ACC_W-1:0] r;
      r = a >>> SHIFT;
      if (r > $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}}))
         scale_out = {1'b0, {(OUT_W-1){1'b1}}};
      else if (r < $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}}))
         scale_out = {1'b1, {(OUT_W-1){1'b0}}};
      else
         scale_out = OUT_W'(r);
`else
      scale_out = OUT_W'(a >>> SHIFT);
`endif
   endfunction

   assign last_tap = (tap_cnt == TAP_AW'(TAPS-1));
   assign last_ch  = (ch_cnt == CH_W'(NUM_CH-1));
   assign x_sel    = x[ch_cnt][tap_cnt];
   assign c_sel    = coef[tap_cnt];

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      coef_busy = 1'b1;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready  = 1'b1;
            coef_busy = 1'b0;
            if (in_valid) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            mac_clr = 1'b1;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            mac_en  = 1'b1;
            mac_clr = last_tap;
            if (last_tap && last_ch) state_d = ST_OUT;
         end
         ST_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tap_cnt  <= '0;
         ch_cnt   <= '0;
         in_lat   <= '0;
         out_data <= '0;
         for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < TAPS; t++)
               x[c][t] <= '0;
         for (int t = 0; t < TAPS; t++)
            coef[t] <= '0;
      end else begin
         state <= state_d;
         case (state)
            ST_IDLE: begin
               if (in_valid) in_lat <= in_data;
               if (coef_we && (int'(coef_addr) < TAPS)) coef[coef_addr] <= coef_data;
            end
            ST_SHIFT: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  for (int t = TAPS-1; t > 0; t--)
                     x[c][t] <= x[c][t-1];
                  x[c][0] <= in_lat[c*DATA_W +: DATA_W];
               end
               tap_cnt <= '0;
               ch_cnt  <= '0;
            end
            // channel-major sweep; each channel's sum is scaled on its last tap
            ST_MAC: begin
               if (last_tap) begin
                  out_data[int'(ch_cnt)*OUT_W +: OUT_W] <= scale_out(mac_sum);
                  tap_cnt <= '0;
                  ch_cnt  <= last_ch ? '0 : ch_cnt + CH_W'(1);
               end else begin
                  tap_cnt <= tap_cnt + TAP_AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (x_sel),
      .b   (c_sel),
      .sum (mac_sum)
   );

endmodule

// File: tb/tb_fir_tdm_multich.sv
// Directed self-checking bench for fir_tdm_multich at default parameters.
module tb_fir_tdm_multich;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] in_data = '0;
   logic        coef_we = 1'b0;
   logic [2:0]  coef_addr = '0;
   logic [15:0] coef_data = '0;
   logic        coef_busy;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [47:0] out_data;

   logic [15:0] obs [3];
   int          lat;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   fir_tdm_multich dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_busy (coef_busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
      @(negedge clk);
      coef_we = 1'b1; coef_addr = a; coef_data = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic accept_vec(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
      int w;
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      if (in_ready !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
      end
      in_valid = 1'b1; in_data = {d2, d1, d0};
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      if (out_valid !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL out_timeout: out_valid=%b, required 1", out_valid);
      end
      for (int k = 0; k < 3; k++) obs[k] = out_data[k*16 +: 16];
   endtask

   task automatic send_vec(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
      accept_vec(d0, d1, d2);
      wait_out();
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 48'h1234_5678_9abc;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
      n_vec++; if (out_data !== 48'h0) begin n_err++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
      n_vec++; if (coef_busy !== 1'b0) begin n_err++; $display("FAIL reset_coef_busy: got %b, required 0", coef_busy); end
   endtask

   task automatic test_impulse;
      logic signed [15:0] cf;
      logic [15:0]        ex;
      do_reset();
      for (int t = 0; t < 8; t++) write_coef(3'(t), 16'(4096*(t+1)));
      for (int n = 0; n < 8; n++) begin
         send_vec((n == 0) ? 16'h4000 : 16'h0000, 16'h0000, 16'h0000);
         // tap 7 coefficient is 16'h8000, i.e. -1.0, so the last ch0 output is negative
         cf = 16'(4096*(n+1));
         ex = 16'((16384 * int'(cf)) >>> 15);
         n_vec++; if (obs[0] !== ex)    begin n_err++; $display("FAIL impulse_ch0[%0d]: got %h, required %h", n, obs[0], ex); end
         n_vec++; if (obs[1] !== 16'h0) begin n_err++; $display("FAIL impulse_ch1[%0d]: got %h, required 0000", n, obs[1]); end
         n_vec++; if (obs[2] !== 16'h0) begin n_err++; $display("FAIL impulse_ch2[%0d]: got %h, required 0000", n, obs[2]); end
      end
   endtask

   task automatic test_backpressure;
      logic [47:0] snap;
      logic        stable, busy_ok;
      do_reset();
      write_coef(3'd0, 16'h4000);
      out_ready = 1'b0;
      send_vec(16'd1000, 16'd2000, -16'sd3000);
      n_vec++; if (lat !== 26) begin n_err++; $display("FAIL latency: got %0d, required 26", lat); end
      n_vec++; if (obs[0] !== 16'd500)   begin n_err++; $display("FAIL bp_ch0: got %h, required %h", obs[0], 16'd500); end
      n_vec++; if (obs[1] !== 16'd1000)  begin n_err++; $display("FAIL bp_ch1: got %h, required %h", obs[1], 16'd1000); end
      n_vec++; if (obs[2] !== -16'sd1500) begin n_err++; $display("FAIL bp_ch2: got %h, required %h", obs[2], -16'sd1500); end
      snap = out_data; stable = 1'b1; busy_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_data !== snap || out_valid !== 1'b1) stable = 1'b0;
         if (in_ready !== 1'b0) busy_ok = 1'b0;
      end
      n_vec++; if (stable !== 1'b1)  begin n_err++; $display("FAIL bp_hold: got %b, required 1", stable); end
      n_vec++; if (busy_ok !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_low: got %b, required 1", busy_ok); end
      out_ready = 1'b1;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_in_ready: got %b, required 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid: got %b, required 0", out_valid); end
   endtask

   task automatic test_saturation;
      logic [15:0] ex;
`ifdef FIR_SAT_EN
      ex = 16'h7FFF;
`else
      ex = 16'hFFF0;
`endif
      do_reset();
      for (int t = 0; t < 8; t++) write_coef(3'(t), 16'h7FFF);
      for (int n = 0; n < 8; n++) begin
         send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF);
         if (n == 0) begin
            n_vec++; if (obs[0] !== 16'h7FFE) begin n_err++; $display("FAIL sat_first: got %h, required 7ffe", obs[0]); end
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (obs[k] !== ex) begin n_err++; $display("FAIL sat_ch%0d: got %h, required %h", k, obs[k], ex); end
      end
   endtask

   task automatic test_reset_mid_mac;
      do_reset();
      write_coef(3'd0, 16'h4000);
      send_vec(16'h2000, 16'h2000, 16'h2000);
      accept_vec(16'h3000, 16'h3000, 16'h3000);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midmac_out_valid: got %b, required 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL midmac_in_ready: got %b, required 1", in_ready); end
      // coefficients were cleared, so this vector must produce zero
      send_vec(16'h1000, 16'h1000, 16'h1000);
      n_vec++; if (obs[0] !== 16'h0) begin n_err++; $display("FAIL midmac_coef_cleared: got %h, required 0000", obs[0]); end
      for (int t = 0; t < 3; t++) write_coef(3'(t), 16'h4000);
      // taps now hold 1000,1000,0: any stale pre-reset sample would add to this
      send_vec(16'h1000, 16'h1000, 16'h1000);
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (obs[k] !== 16'h1000) begin n_err++; $display("FAIL midmac_delay_cleared_ch%0d: got %h, required 1000", k, obs[k]); end
      end
   endtask

   task automatic test_coef_busy;
      logic busy_seen;
      do_reset();
      write_coef(3'd0, 16'h4000);
      accept_vec(16'h1000, 16'h1000, 16'h1000);
      busy_seen = 1'b1;
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (coef_busy !== 1'b1) busy_seen = 1'b0;
      end
      coef_we = 1'b0;
      n_vec++; if (busy_seen !== 1'b1) begin n_err++; $display("FAIL coef_busy_high: got %b, required 1", busy_seen); end
      wait_out();
      n_vec++; if (obs[0] !== 16'h0800) begin n_err++; $display("FAIL coef_busy_cur: got %h, required 0800", obs[0]); end
      send_vec(16'h1000, 16'h1000, 16'h1000);
      n_vec++; if (obs[0] !== 16'h0800) begin n_err++; $display("FAIL coef_busy_next_ch0: got %h, required 0800", obs[0]); end
      n_vec++; if (obs[2] !== 16'h0800) begin n_err++; $display("FAIL coef_busy_next_ch2: got %h, required 0800", obs[2]); end
   endtask

   task automatic test_channel_isolation;
      do_reset();
      write_coef(3'd0, 16'h8000);
      send_vec(16'd100, -16'sd100, 16'd0);
      n_vec++; if (obs[0] !== -16'sd100) begin n_err++; $display("FAIL iso_ch0: got %h, required %h", obs[0], -16'sd100); end
      n_vec++; if (obs[1] !== 16'd100)   begin n_err++; $display("FAIL iso_ch1: got %h, required %h", obs[1], 16'd100); end
      n_vec++; if (obs[2] !== 16'd0)     begin n_err++; $display("FAIL iso_ch2: got %h, required 0000", obs[2]); end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_backpressure();
      test_saturation();
      test_reset_mid_mac();
      test_coef_busy();
      test_channel_isolation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
